// File: rtl/snake_motion_ctrl.sv
// Snake head motion controller: frame-divided stepping, reversal-safe steering.
// Define WRAP_EN for a toroidal playfield; otherwise walls collide and halt.
module snake_motion_ctrl #(
  parameter int         GRID_W    = 40,
  parameter int         GRID_H    = 30,
  parameter int         STEP_DIV  = 8,
  parameter int         START_X   = 20,
  parameter int         START_Y   = 15,
  parameter logic [1:0] START_DIR = 2'b11
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       Load,
  input  logic [1:0] motionFlag,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] dir,
  output logic       step,
  output logic       collide
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      pend, pend_n;
  logic [1:0]      dir_n;
  logic [5:0]      x_n;
  logic [4:0]      y_n;
  logic            step_n, col_n;
  logic            commit, rev;
  logic [6:0]      nx;
  logic [5:0]      ny;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      head_x  <= 6'(START_X);
      head_y  <= 5'(START_Y);
      dir     <= START_DIR;
      pend    <= START_DIR;
      cnt     <= '0;
      step    <= 1'b0;
      collide <= 1'b0;
    end else begin
      state   <= state_n;
      head_x  <= x_n;
      head_y  <= y_n;
      dir     <= dir_n;
      pend    <= pend_n;
      cnt     <= cnt_n;
      step    <= step_n;
      collide <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = head_x;
    y_n     = head_y;
    dir_n   = dir;
    pend_n  = pend;
    cnt_n   = cnt;
    step_n  = 1'b0;
    col_n   = collide;
    commit  = 1'b0;
    rev     = 1'b0;
    nx      = {1'b0, head_x};
    ny      = {1'b0, head_y};
    unique case (state)
      IDLE: begin
        if (enable && Load) begin
          state_n = RUN;
          pend_n  = motionFlag;
        end
      end
      RUN: begin
        if (enable) begin
          commit = frame_tick && (cnt == CMAX);
          // a key on the commit cycle is judged against the move in flight
          rev = ((motionFlag ^ (commit ? pend : dir)) == 2'b10);
          if (Load && !rev) pend_n = motionFlag;
          if (frame_tick) cnt_n = commit ? '0 : cnt + 1'b1;
          if (commit) begin
            dir_n = pend;
            unique case (pend)
              2'b00: ny = ny - 1'b1;
              2'b01: nx = nx - 1'b1;
              2'b10: ny = ny + 1'b1;
              2'b11: nx = nx + 1'b1;
            endcase
`ifdef WRAP_EN
            if (nx[6]) nx = 7'(GRID_W - 1);
            else if (nx >= 7'(GRID_W)) nx = '0;
            if (ny[5]) ny = 6'(GRID_H - 1);
            else if (ny >= 6'(GRID_H)) ny = '0;
            x_n    = nx[5:0];
            y_n    = ny[4:0];
            step_n = 1'b1;
`else
            if (nx[6] || nx >= 7'(GRID_W) ||
                ny[5] || ny >= 6'(GRID_H)) begin
              col_n   = 1'b1;
              state_n = HALT;
            end else begin
              x_n    = nx[5:0];
              y_n    = ny[4:0];
              step_n = 1'b1;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Scoreboard bench for snake_motion_ctrl (STEP_DIV=2).
// Expected head moves are queued as stimulus is driven and popped on step.
module tb_snake_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, enable, Load;
  logic [1:0] motionFlag;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       step, collide;

  int n_run = 0;
  int n_fail = 0;
  logic [12:0] sb[$];

  snake_motion_ctrl #(
    .GRID_W(40), .GRID_H(30), .STEP_DIV(2),
    .START_X(20), .START_Y(15), .START_DIR(2'b11)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .enable(enable), .Load(Load), .motionFlag(motionFlag),
    .head_x(head_x), .head_y(head_y), .dir(dir),
    .step(step), .collide(collide)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (step === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_step", 1, 0);
      else chk("step_xyd", {head_x, head_y, dir}, sb.pop_front());
    end
  end

  task automatic push(input int x, input int y, input logic [1:0] d);
    sb.push_back({6'(x), 5'(y), d});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic load(input logic [1:0] d);
    Load = 1'b1;
    motionFlag = d;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y,
                         input logic [1:0] d);
    chk(tag, {head_x, head_y, dir}, {6'(x), 5'(y), d});
  endtask

  task automatic chk_reset(input string tag);
    chk_pos(tag, 20, 15, 2'b11);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_col"}, collide, 0);
  endtask

  initial begin
    Reset = 1'b1;
    frame_tick = 1'b0;
    enable = 1'b0;
    Load = 1'b0;
    motionFlag = 2'b00;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk_reset("reset");

    // IDLE ignores frame_tick
    enable = 1'b1;
    tick(3);
    chk_pos("idle_hold", 20, 15, 2'b11);

    // start moving up
    load(2'b00);
    push(20, 14, 2'b00);
    tick(2);
    chk("sb_up", sb.size(), 0);

    // reversal ignored, then turn left
    load(2'b10);
    load(2'b01);
    push(19, 14, 2'b01);
    tick(2);
    chk("sb_left", sb.size(), 0);

    // key on commit cycle applies to the following step
    load(2'b00);
    tick(1);
    push(19, 13, 2'b00);
    frame_tick = 1'b1;
    Load = 1'b1;
    motionFlag = 2'b01;
    @(negedge Clk);
    frame_tick = 1'b0;
    Load = 1'b0;
    @(negedge Clk);
    push(18, 13, 2'b01);
    tick(2);
    chk("sb_commit_load", sb.size(), 0);

    // freeze
    enable = 1'b0;
    tick(5);
    load(2'b11);
    chk_pos("frozen", 18, 13, 2'b01);
    enable = 1'b1;
    push(17, 13, 2'b01);
    tick(2);
    chk("sb_unfreeze", sb.size(), 0);

    // run to the left wall
    for (int i = 16; i >= 0; i--) begin
      push(i, 13, 2'b01);
      tick(2);
    end
    chk_pos("at_wall", 0, 13, 2'b01);
    chk("sb_wall", sb.size(), 0);

`ifdef WRAP_EN
    push(39, 13, 2'b01);
    tick(2);
    chk_pos("wrapped", 39, 13, 2'b01);
    chk("wrap_col", collide, 0);
    tick(1);
`else
    tick(2);
    chk_pos("collide_pos", 0, 13, 2'b01);
    chk("collide", collide, 1);
    load(2'b00);
    tick(4);
    chk_pos("halt_hold", 0, 13, 2'b01);
    chk("halt_col", collide, 1);
`endif

    // reset from HALT / mid-count
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk_reset("reset2");

    // IDLE start without reversal check, then turn
    load(2'b10);
    push(20, 16, 2'b10);
    tick(2);
    load(2'b11);
    push(21, 16, 2'b11);
    tick(2);
    chk("sb_down_right", sb.size(), 0);

    // reset beats a commit-cycle frame_tick
    tick(1);
    Reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    frame_tick = 1'b0;
    chk_reset("reset_mid");
    tick(2);
    chk_pos("idle_after", 20, 15, 2'b11);
    chk("sb_final", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_motion_ctrl.md
SNAKE_MOTION_CTRL -- requirements
Module: snake_motion_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- GRID_W, 40, playfield width in cells
- GRID_H, 30, playfield height in cells
- STEP_DIV, 8, frame_tick pulses per head step (>=1)
- START_X, 20, head column after reset
- START_Y, 15, head row after reset
- START_DIR, 2'b11, direction after reset
REQ-002 Ports SHALL be, one per line:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- enable  in  1  game running; 0 freezes the block
- Load  in  1  a direction key is pressed this cycle
- motionFlag  in  2  requested direction: 00 up, 01 left, 10 down, 11 right
- head_x  out  6  head column, 0..GRID_W-1
- head_y  out  5  head row, 0..GRID_H-1
- dir  out  2  committed direction, same encoding as motionFlag
- step  out  1  one-cycle pulse after each head move
- collide  out  1  wall hit; sticky

Function
REQ-003 The block SHALL have three states: IDLE, RUN and HALT.
REQ-004 IDLE->RUN SHALL occur on a cycle with enable=1 and Load=1. That Load SHALL set pend_dir to motionFlag with no reversal check.
REQ-005 In RUN with enable=1, Load SHALL update pend_dir unless the request is a reversal.
- Reversal: (motionFlag XOR ref) == 2'b10.
- ref = pend_dir on a commit cycle (REQ-007), dir otherwise.
REQ-006 In RUN with enable=1, the 0..STEP_DIV-1 frame counter SHALL advance on each frame_tick.
REQ-007 A frame_tick with counter==STEP_DIV-1 SHALL be a commit cycle. On that clock edge:
- dir <= pend_dir
- head moves one cell in pend_dir (up: y-1, down: y+1, left: x-1, right: x+1)
- counter <= 0
REQ-008 step SHALL be 1 for exactly the cycle after a commit edge, coincident with the new head_x/head_y.
REQ-009 A Load on a commit cycle SHALL NOT affect that move; it SHALL apply to the next step only.
REQ-010 enable=0 SHALL freeze the counter, pend_dir, head, dir and state, and SHALL ignore Load and frame_tick. No step SHALL pulse while frozen.
REQ-011 IDLE SHALL ignore frame_tick. head_x, head_y and dir SHALL hold at their start values in IDLE.
REQ-012 HALT SHALL ignore all inputs until Reset. Outputs SHALL hold. step SHALL stay 0.
REQ-013 Arithmetic: next-position computation SHALL use one extra bit to detect underflow below 0 and overflow past GRID_W-1 / GRID_H-1.

Reset
REQ-014 When Reset=1 on a clock edge, the block SHALL load: state IDLE, head_x=START_X, head_y=START_Y, dir=pend_dir=START_DIR, counter=0, step=0, collide=0.
REQ-015 Reset SHALL take priority over every other input, including mid-step and in HALT.

Configuration
REQ-016 With WRAP_EN defined, an out-of-grid move SHALL wrap.
- x: -1 -> GRID_W-1; GRID_W -> 0. y likewise with GRID_H.
- collide SHALL stay 0 and HALT SHALL be unreachable.
REQ-017 Without WRAP_EN, an out-of-grid move SHALL behave as follows on the commit edge:
- head position unchanged
- dir updated
- collide <= 1
- state -> HALT
- step not pulsed

Verification (GRID_W=40, GRID_H=30, STEP_DIV=2, start (20,15), dir 11)
REQ-018 Reset, then Load=1/motionFlag=00/enable=1, then 2 frame_ticks -> RUN; head (20,14); dir=00; one step pulse.
REQ-019 In RUN with dir=00, Load motionFlag=10 -> ignored. Load motionFlag=01 -> next step moves head to (19,14).
REQ-020 Load motionFlag=01 on a commit cycle while pend_dir=00 -> this move is up. The following move is left.
REQ-021 Head at (0,14) moving left, 2 ticks:
- without WRAP_EN -> collide=1, head stays (0,14), HALT, no further steps.
- with WRAP_EN -> head (39,14), collide=0.
REQ-022 enable=0 for 5 frame_ticks and a Load -> no change.
REQ-023 Reset asserted mid-count in RUN -> all outputs return to REQ-014 values on the next edge.
